// File: rtl/cbfp_pkg.sv
// Shared widths and lane-array types for the CBFP reorder buffer.
package cbfp_pkg;

  localparam int unsigned ARRAY_SIZE = 16;
  localparam int unsigned BEAT_NUM   = 4;
  localparam int unsigned DIN_SIZE   = 11;
  localparam int unsigned CNT_SIZE   = 5;
  localparam int unsigned BEAT_W     = $clog2(BEAT_NUM);
  localparam int unsigned LANE_W     = $clog2(ARRAY_SIZE);

  typedef logic signed [DIN_SIZE-1:0] sample_t;
  typedef logic        [CNT_SIZE-1:0] idx_t;
  typedef logic        [BEAT_W-1:0]   beat_t;

  typedef sample_t lane_t     [0:ARRAY_SIZE-1];
  typedef idx_t    idx_lane_t [0:ARRAY_SIZE-1];

endpackage

// File: rtl/cbfp_pingpong_bank.sv
// One ping-pong bank: beat-addressed write, stride-transposed combinational read.
module cbfp_pingpong_bank
  import cbfp_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  beat_t     wr_beat,
  input  lane_t     wr_re,
  input  lane_t     wr_im,
  input  idx_t      wr_idx,
  input  beat_t     rd_beat,
  output lane_t     rd_re_c,
  output lane_t     rd_im_c,
  output idx_lane_t rd_idx_c
);

  sample_t mem_re  [0:BEAT_NUM-1][0:ARRAY_SIZE-1];
  sample_t mem_im  [0:BEAT_NUM-1][0:ARRAY_SIZE-1];
  idx_t    idx_mem [0:BEAT_NUM-1];

  // Capture one input beat into its row, together with its shift index.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < ARRAY_SIZE; l++) begin
        mem_re[wr_beat][l] <= wr_re[l];
        mem_im[wr_beat][l] <= wr_im[l];
      end
      idx_mem[wr_beat] <= wr_idx;
    end
  end

  // Output lane l of beat r is sample BEAT_NUM*l + r; its source row is fixed per lane.
  for (genvar l = 0; l < ARRAY_SIZE; l++) begin : g_rd
    localparam int unsigned SRC_BEAT = (BEAT_NUM * l) / ARRAY_SIZE;
    localparam int unsigned SRC_LANE = (BEAT_NUM * l) % ARRAY_SIZE;
    logic [LANE_W-1:0] sel;
    assign sel         = LANE_W'(SRC_LANE) + LANE_W'(rd_beat);
    assign rd_re_c[l]  = mem_re[SRC_BEAT][sel];
    assign rd_im_c[l]  = mem_im[SRC_BEAT][sel];
    assign rd_idx_c[l] = idx_mem[SRC_BEAT];
  end

endmodule

// File: rtl/cbfp_reorder_buf.sv
// Double-buffered stride transpose of 64-point CBFP blocks (4 beats x 16 lanes).
module cbfp_reorder_buf
  import cbfp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      valid_in,
  input  lane_t     din_re,
  input  lane_t     din_im,
  input  idx_t      idx_in,
  output logic      valid_out,
  output lane_t     dout_re,
  output lane_t     dout_im,
  output idx_lane_t idx_out,
  output logic      blk_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;
  localparam beat_t      LAST_BEAT = beat_t'(BEAT_NUM - 1);

  logic [0:0] state, state_nxt;
  beat_t      wr_beat, rd_beat, rd_beat_nxt;
  logic       wr_bank, rd_bank, rd_bank_nxt;
  logic [1:0] bank_full, full_or_set, wr_set_c, rd_clr_c;
  logic       ovf;
  logic       we_c, wr_done_c, rd_last_c;

  lane_t     b0_re_c, b0_im_c, b1_re_c, b1_im_c;
  idx_lane_t b0_idx_c, b1_idx_c;

  // A write into a still-full bank is dropped rather than corrupting it.
  assign we_c        = valid_in & ~bank_full[wr_bank];
  assign wr_done_c   = we_c & (wr_beat == LAST_BEAT);
  assign wr_set_c    = {wr_done_c & wr_bank, wr_done_c & ~wr_bank};
  assign rd_clr_c    = {rd_last_c & rd_bank, rd_last_c & ~rd_bank};
  // A bank completing this cycle counts as full so reading starts without a bubble.
  assign full_or_set = bank_full | wr_set_c;

  cbfp_pingpong_bank u_bank0 (
    .clk      (clk),
    .we       (we_c & ~wr_bank),
    .wr_beat  (wr_beat),
    .wr_re    (din_re),
    .wr_im    (din_im),
    .wr_idx   (idx_in),
    .rd_beat  (rd_beat),
    .rd_re_c  (b0_re_c),
    .rd_im_c  (b0_im_c),
    .rd_idx_c (b0_idx_c)
  );

  cbfp_pingpong_bank u_bank1 (
    .clk      (clk),
    .we       (we_c & wr_bank),
    .wr_beat  (wr_beat),
    .wr_re    (din_re),
    .wr_im    (din_im),
    .wr_idx   (idx_in),
    .rd_beat  (rd_beat),
    .rd_re_c  (b1_re_c),
    .rd_im_c  (b1_im_c),
    .rd_idx_c (b1_idx_c)
  );

  // Write pointer, bank toggle and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_beat <= '0;
      wr_bank <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf <= ovf | (valid_in & bank_full[wr_bank]);
      if (we_c) begin
        wr_beat <= wr_done_c ? '0 : wr_beat + beat_t'(1);
        if (wr_done_c) wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank occupancy: set on last written beat, cleared on last read beat.
  always_ff @(posedge clk) begin
    if (rst) bank_full <= '0;
    else     bank_full <= (bank_full & ~rd_clr_c) | wr_set_c;
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_beat <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_beat <= rd_beat_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // Read FSM next state: lowest full bank first, chain straight into the other bank.
  always_comb begin
    state_nxt   = state;
    rd_beat_nxt = rd_beat;
    rd_bank_nxt = rd_bank;
    rd_last_c   = 1'b0;
    case (state)
      S_IDLE: begin
        rd_beat_nxt = '0;
        if (full_or_set[0]) begin
          state_nxt   = S_READ;
          rd_bank_nxt = 1'b0;
        end else if (full_or_set[1]) begin
          state_nxt   = S_READ;
          rd_bank_nxt = 1'b1;
        end
      end
      S_READ: begin
        if (rd_beat == LAST_BEAT) begin
          rd_last_c   = 1'b1;
          rd_beat_nxt = '0;
          if (full_or_set[~rd_bank]) rd_bank_nxt = ~rd_bank;
          else                       state_nxt   = S_IDLE;
        end else begin
          rd_beat_nxt = rd_beat + beat_t'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output registers; data holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      blk_done  <= 1'b0;
      for (int l = 0; l < ARRAY_SIZE; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
        idx_out[l] <= '0;
      end
    end else begin
      valid_out <= (state == S_READ);
      blk_done  <= rd_last_c;
      if (state == S_READ) begin
        for (int l = 0; l < ARRAY_SIZE; l++) begin
          dout_re[l] <= rd_bank ? b1_re_c[l]  : b0_re_c[l];
          dout_im[l] <= rd_bank ? b1_im_c[l]  : b0_im_c[l];
          idx_out[l] <= rd_bank ? b1_idx_c[l] : b0_idx_c[l];
        end
      end
    end
  end

endmodule

// File: doc/cbfp_reorder_buf.md
Name: cbfp_reorder_buf

Overview:
- Sits directly downstream of the CBFP stage.
- Captures each 64-point block as four beats of 16 lanes of complex samples (11 b re/im), plus the per-beat CBFP shift index.
- Re-emits each block in stride-4 transposed order for the next butterfly stage.
- Ping-pong double buffer: one bank fills while the other drains. No backpressure is needed.

Parameters:
- array_size, 16, lanes per beat
- beat_num, 4, beats per block (block = array_size*beat_num = 64 samples)
- din_size, 11, sample width (re and im each, signed)
- cnt_size, 5, CBFP shift-index width (unsigned)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  input beat valid
- din_re  in  signed [din_size-1:0] x [0:array_size-1]  real lanes
- din_im  in  signed [din_size-1:0] x [0:array_size-1]  imag lanes
- idx_in  in  [cnt_size-1:0]  CBFP shift index for this beat; sampled with valid_in
- valid_out  out  1  output beat valid
- dout_re  out  signed [din_size-1:0] x [0:array_size-1]  reordered real lanes
- dout_im  out  signed [din_size-1:0] x [0:array_size-1]  reordered imag lanes
- idx_out  out  [cnt_size-1:0] x [0:array_size-1]  shift index per output lane
- blk_done  out  1  one-cycle pulse coincident with the last output beat of a block

Behaviour:
- Reset (rst=1 at an edge):
  - wr_beat=0, wr_bank=0, both bank_full=0, rd_active=0, rd_beat=0.
  - valid_out=0, blk_done=0; dout_re, dout_im and idx_out all 0.
  - Storage contents need not be cleared.
  - A partial block in progress at reset is discarded.
- Write side:
  - On a valid_in edge: store lane l as sample s=16*wr_beat+l in bank wr_bank, and store idx_in as beat index idx[wr_beat].
  - Then increment wr_beat.
  - Gaps (valid_in=0) are allowed mid-block; wr_beat holds during gaps.
  - When wr_beat==beat_num-1 is written: wr_beat wraps to 0, bank_full[wr_bank] is set, and wr_bank toggles.
- Read side state machine:
  - IDLE: if any bank is full, go to READ. Take the lowest-numbered full bank if both are full; in practice this cannot occur except after a write bank toggles.
  - READ: lasts exactly beat_num consecutive cycles. rd_beat runs 0..beat_num-1 with no gaps.
  - Each read cycle registers output beat r: dout lane l = sample 4*l+r of the read bank, and idx_out[l] = idx[l>>2].
  - On the last read beat: clear bank_full for the read bank, pulse blk_done, and return to IDLE. If the other bank is already full, go directly to READ of that bank with no idle cycle.
- Latency:
  - The last input beat of a block is accepted at edge k.
  - valid_out is high for the cycles following edges k+1..k+4, carrying beats r=0..3.
  - The first output beat therefore appears 1 cycle after the last input beat.
- Outputs when valid_out=0: dout and idx_out hold their last value; they are not forced to 0.
- Simultaneous events: a write to bank B in the same cycle as a read from bank A is legal. A write completing in the same cycle that the read of the other bank finishes produces back-to-back output blocks.
- Overflow: cannot occur when input follows the stage's rate of at most 4 beats per 4 cycles. If a write targets a bank with bank_full=1, the write is dropped and a sticky internal ovf flag is set; it is cleared by rst. The bench asserts that it never fires.
- Width rules: no arithmetic on data; samples pass bit-exact. idx values pass unchanged.

Decomposition:
- Package cbfp_pkg:
  - ARRAY_SIZE, BEAT_NUM, DIN_SIZE, CNT_SIZE constants
  - sample_t (signed [DIN_SIZE-1:0]) typedef
  - idx_t typedef
  - lane-array typedefs
- Sub-module cbfp_pingpong_bank: one bank with 4x16 complex storage, 4 idx registers, a write port by beat and a transposed read port by rd_beat. Instantiated twice. The top level holds the write/read control and output registers.

Test Plan:
- Single block, sample value = its index s (re=s, im=-s), idx_in=3,5,7,9 over 4 consecutive beats:
  - valid_out high 4 cycles starting 1 cycle after the last input.
  - Beat 0 lanes = 0,4,8,...,60; beat 3 = 3,7,...,63.
  - idx_out = 3,3,3,3,5,5,5,5,7,7,7,7,9,9,9,9.
  - blk_done only on beat 3.
- Three blocks back-to-back, 12 consecutive valid_in cycles:
  - 12 consecutive valid_out cycles with no bubbles.
  - Blocks emerge in order with correct bank alternation.
  - ovf stays 0.
- Input with gaps (pattern valid_in 1,0,1,0,0,1,1):
  - Output is identical to the gap-free case.
  - Output starts 1 cycle after the 4th accepted beat.
- rst asserted after 2 beats of a block, then a fresh full block:
  - Only the fresh block is output.
  - No valid_out for the discarded partial block.
- rst asserted mid-READ (after beat 1 out):
  - valid_out=0, dout=0 and blk_done=0 on the next cycle.
  - A subsequent block is output normally.
- Extreme values: lanes = -1024 and +1023 alternating, idx=31 on all beats. Outputs are bit-exact, with sign preserved.
